// File: rtl/sha2_k_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | sha2_k_sequencer                                                      |
// | Registered, stallable SHA-256/SHA-512 round-constant stream.          |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module sha2_k_sequencer #(
  parameter  int VARIANT = 256,
  localparam int WORD_W  = (VARIANT == 512) ? 64 : 32,
  localparam int RND_W   = 7
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              abort_i,
  output logic [WORD_W-1:0] k_o,
  output logic [RND_W-1:0]  round_o,
  output logic              valid_o,
  output logic              first_o,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int              NUM_ROUNDS = (VARIANT == 512) ? 80 : 64;
  localparam logic [RND_W-1:0] LAST_RND  = RND_W'(NUM_ROUNDS - 1);

  generate
    if (VARIANT != 256 && VARIANT != 512) begin : g_bad_variant
      $error("sha2_k_sequencer: VARIANT must be 256 or 512");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // SHA-256 constants are the upper 32 bits of the first 64 SHA-512 constants.
  function automatic logic [63:0] k_rom(input logic [RND_W-1:0] idx);
    logic [63:0] k;
    k = '0;
    case (idx)
      7'd0:  k = 64'h428a2f98d728ae22;  7'd1:  k = 64'h7137449123ef65cd;
      7'd2:  k = 64'hb5c0fbcfec4d3b2f;  7'd3:  k = 64'he9b5dba58189dbbc;
      7'd4:  k = 64'h3956c25bf348b538;  7'd5:  k = 64'h59f111f1b605d019;
      7'd6:  k = 64'h923f82a4af194f9b;  7'd7:  k = 64'hab1c5ed5da6d8118;
      7'd8:  k = 64'hd807aa98a3030242;  7'd9:  k = 64'h12835b0145706fbe;
      7'd10: k = 64'h243185be4ee4b28c;  7'd11: k = 64'h550c7dc3d5ffb4e2;
      7'd12: k = 64'h72be5d74f27b896f;  7'd13: k = 64'h80deb1fe3b1696b1;
      7'd14: k = 64'h9bdc06a725c71235;  7'd15: k = 64'hc19bf174cf692694;
      7'd16: k = 64'he49b69c19ef14ad2;  7'd17: k = 64'hefbe4786384f25e3;
      7'd18: k = 64'h0fc19dc68b8cd5b5;  7'd19: k = 64'h240ca1cc77ac9c65;
      7'd20: k = 64'h2de92c6f592b0275;  7'd21: k = 64'h4a7484aa6ea6e483;
      7'd22: k = 64'h5cb0a9dcbd41fbd4;  7'd23: k = 64'h76f988da831153b5;
      7'd24: k = 64'h983e5152ee66dfab;  7'd25: k = 64'ha831c66d2db43210;
      7'd26: k = 64'hb00327c898fb213f;  7'd27: k = 64'hbf597fc7beef0ee4;
      7'd28: k = 64'hc6e00bf33da88fc2;  7'd29: k = 64'hd5a79147930aa725;
      7'd30: k = 64'h06ca6351e003826f;  7'd31: k = 64'h142929670a0e6e70;
      7'd32: k = 64'h27b70a8546d22ffc;  7'd33: k = 64'h2e1b21385c26c926;
      7'd34: k = 64'h4d2c6dfc5ac42aed;  7'd35: k = 64'h53380d139d95b3df;
      7'd36: k = 64'h650a73548baf63de;  7'd37: k = 64'h766a0abb3c77b2a8;
      7'd38: k = 64'h81c2c92e47edaee6;  7'd39: k = 64'h92722c851482353b;
      7'd40: k = 64'ha2bfe8a14cf10364;  7'd41: k = 64'ha81a664bbc423001;
      7'd42: k = 64'hc24b8b70d0f89791;  7'd43: k = 64'hc76c51a30654be30;
      7'd44: k = 64'hd192e819d6ef5218;  7'd45: k = 64'hd69906245565a910;
      7'd46: k = 64'hf40e35855771202a;  7'd47: k = 64'h106aa07032bbd1b8;
      7'd48: k = 64'h19a4c116b8d2d0c8;  7'd49: k = 64'h1e376c085141ab53;
      7'd50: k = 64'h2748774cdf8eeb99;  7'd51: k = 64'h34b0bcb5e19b48a8;
      7'd52: k = 64'h391c0cb3c5c95a63;  7'd53: k = 64'h4ed8aa4ae3418acb;
      7'd54: k = 64'h5b9cca4f7763e373;  7'd55: k = 64'h682e6ff3d6b2b8a3;
      7'd56: k = 64'h748f82ee5defb2fc;  7'd57: k = 64'h78a5636f43172f60;
      7'd58: k = 64'h84c87814a1f0ab72;  7'd59: k = 64'h8cc702081a6439ec;
      7'd60: k = 64'h90befffa23631e28;  7'd61: k = 64'ha4506cebde82bde9;
      7'd62: k = 64'hbef9a3f7b2c67915;  7'd63: k = 64'hc67178f2e372532b;
      7'd64: k = 64'hca273eceea26619c;  7'd65: k = 64'hd186b8c721c0c207;
      7'd66: k = 64'heada7dd6cde0eb1e;  7'd67: k = 64'hf57d4f7fee6ed178;
      7'd68: k = 64'h06f067aa72176fba;  7'd69: k = 64'h0a637dc5a2c898a6;
      7'd70: k = 64'h113f9804bef90dae;  7'd71: k = 64'h1b710b35131c471b;
      7'd72: k = 64'h28db77f523047d84;  7'd73: k = 64'h32caab7b40c72493;
      7'd74: k = 64'h3c9ebe0a15c9bebc;  7'd75: k = 64'h431d67c49c100d4c;
      7'd76: k = 64'h4cc5d4becb3e42b6;  7'd77: k = 64'h597f299cfc657e2a;
      7'd78: k = 64'h5fcb6fab3ad6faec;  7'd79: k = 64'h6c44198c4a475817;
      default: k = '0;
    endcase
    return k;
  endfunction

  state_t            state_q, state_d;
  logic [RND_W-1:0]  rnd_q, rnd_d;
  logic [WORD_W-1:0] k_q, k_d;
  logic [63:0]       rom_word;
  logic              load, done_d, done_q;

  assign rom_word = k_rom(rnd_d);
  assign k_d      = WORD_W'(rom_word >> (64 - WORD_W));

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    load    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          state_d = RUN;
          rnd_d   = '0;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (!stall_i) begin
          if (rnd_q != LAST_RND) begin
            rnd_d = rnd_q + 1'b1;
            load  = 1'b1;
          end else begin
            done_d = 1'b1;
            // Start during the final advance chains the next sequence with no bubble.
            if (start_i) begin
              rnd_d = '0;
              load  = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (load) begin
        rnd_q <= rnd_d;
        k_q   <= k_d;
      end
    end
  end

  assign k_o     = k_q;
  assign round_o = rnd_q;
  assign valid_o = (state_q == RUN);
  assign busy_o  = valid_o;
  assign first_o = valid_o && (rnd_q == '0);
  assign last_o  = valid_o && (rnd_q == LAST_RND);
  assign done_o  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sha2_k_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_sha2_k_sequencer                                                   |
// | Scoreboard bench for both SHA-2 variants of the K sequencer.          |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_sha2_k_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start_a, stall_a, abort_a, start_b, stall_b, abort_b;
  logic [31:0] k_a;
  logic [63:0] k_b;
  logic [6:0]  round_a, round_b;
  logic        valid_a, first_a, last_a, busy_a, done_a;
  logic        valid_b, first_b, last_b, busy_b, done_b;
  logic        stall_en;

  sha2_k_sequencer #(.VARIANT(256)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .stall_i(stall_a), .abort_i(abort_a),
    .k_o(k_a), .round_o(round_a), .valid_o(valid_a), .first_o(first_a), .last_o(last_a),
    .busy_o(busy_a), .done_o(done_a)
  );

  sha2_k_sequencer #(.VARIANT(512)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .stall_i(stall_b), .abort_i(abort_b),
    .k_o(k_b), .round_o(round_b), .valid_o(valid_b), .first_o(first_b), .last_o(last_b),
    .busy_o(busy_b), .done_o(done_b)
  );

  logic [31:0] K256 [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    int          rnd;
    logic [63:0] k;
    logic [63:0] mask;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push_a(input int lo, input int hi);
    exp_t e;
    for (int r = lo; r <= hi; r++) begin
      e.rnd = r; e.k = {32'h0, K256[r]}; e.mask = '1;
      q_a.push_back(e);
    end
  endtask

  task automatic push_b();
    exp_t e;
    for (int r = 0; r < 80; r++) begin
      e.rnd = r;
      if (r == 0) begin
        e.k = 64'h428a2f98d728ae22; e.mask = '1;
      end else if (r == 79) begin
        e.k = 64'h6c44198c4a475817; e.mask = '1;
      end else if (r < 64) begin
        e.k = {K256[r], 32'h0}; e.mask = 64'hffffffff00000000;
      end else begin
        e.k = '0; e.mask = '0;
      end
      q_b.push_back(e);
    end
  endtask

  // Monitor A: consumed words against the scoreboard, plus stall stability.
  logic [43:0] snap_a;
  logic        held_a;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (held_a)
        check("a_stall_hold", {k_a, round_a, valid_a, first_a, last_a, busy_a}, snap_a);
      if (valid_a && !stall_a) begin
        if (q_a.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL a_unexpected_word: got round %0d, expected no word", round_a);
        end else begin
          e = q_a.pop_front();
          check("a_round", round_a, e.rnd);
          check("a_k", k_a, e.k);
          check("a_first", first_a, e.rnd == 0);
          check("a_last", last_a, e.rnd == 63);
        end
      end
    end
    held_a <= rst_n && valid_a && stall_a && !abort_a;
    snap_a <= {k_a, round_a, valid_a, first_a, last_a, busy_a};
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && valid_b && !stall_b) begin
      if (q_b.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL b_unexpected_word: got round %0d, expected no word", round_b);
      end else begin
        e = q_b.pop_front();
        check("b_round", round_b, e.rnd);
        if (e.mask != '0) check("b_k", k_b & e.mask, e.k & e.mask);
        check("b_first", first_b, e.rnd == 0);
        check("b_last", last_b, e.rnd == 79);
      end
    end
  end

  initial begin
    stall_a = 1'b0;
    forever begin
      @(posedge clk); #1;
      stall_a = stall_en ? ($urandom_range(0, 99) < 30) : 1'b0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Waits for done_a; expected cycle count follows from the stall pattern seen.
  task automatic wait_done(input int n_words, input int offset, input string name);
    int n = 0, stalls = 0, consumed = 0;
    bit seen = 0;
    while (!seen && n < 1000) begin
      @(negedge clk);
      n++;
      if (consumed < n_words) begin
        if (stall_a) stalls++;
        else consumed++;
      end
      if (done_a) seen = 1;
    end
    if (!seen) begin
      vectors++; miscompares++;
      $display("FAIL %s_timeout: got no done_o after %0d cycles, expected a pulse", name, n);
    end else begin
      check({name, "_len"}, n, n_words + stalls + offset);
      @(negedge clk);
      check({name, "_done_width"}, done_a, 0);
      check({name, "_valid_after"}, valid_a, 0);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a_k"}, k_a, 0);         check({tag, "_a_round"}, round_a, 0);
    check({tag, "_a_valid"}, valid_a, 0); check({tag, "_a_first"}, first_a, 0);
    check({tag, "_a_last"}, last_a, 0);   check({tag, "_a_busy"}, busy_a, 0);
    check({tag, "_a_done"}, done_a, 0);
  endtask

  initial begin
    int n, nvalid;
    bit seen;
    rst_n = 1'b0; start_a = 0; abort_a = 0; start_b = 0; stall_b = 0; abort_b = 0; stall_en = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    check("reset_b_k", k_b, 0); check("reset_b_valid", valid_b, 0);
    check("reset_b_busy", busy_b, 0); check("reset_b_done", done_b, 0);
    step(); rst_n = 1'b1;
    step(); step();

    // SHA-256 full sequence, no stall
    push_a(0, 63);
    start_a = 1; step(); start_a = 0;
    wait_done(64, 1, "seq256");
    check("idle_hold_round", round_a, 63);
    check("idle_hold_k", k_a, 32'hc67178f2);
    step(); step();

    // SHA-512 full sequence
    push_b();
    start_b = 1; step(); start_b = 0;
    n = 0; nvalid = 0; seen = 0;
    while (!seen && n < 1000) begin
      @(negedge clk); n++;
      if (valid_b) nvalid++;
      if (done_b) seen = 1;
    end
    check("seq512_done_cycle", n, 81);
    check("seq512_valid_cycles", nvalid, 80);
    @(negedge clk);
    check("seq512_done_width", done_b, 0);
    check("seq512_valid_after", valid_b, 0);
    step(); step();

    // Random stalls
    stall_en = 1;
    push_a(0, 63);
    start_a = 1; step(); start_a = 0;
    wait_done(64, 1, "stall256");
    stall_en = 0;
    step(); step();

    // Abort at round 20
    push_a(0, 20);
    start_a = 1; step(); start_a = 0;
    repeat (20) step();
    abort_a = 1; step(); abort_a = 0;
    @(negedge clk);
    check("abort_valid", valid_a, 0);
    check("abort_busy", busy_a, 0);
    check("abort_hold_round", round_a, 20);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done_a) seen = 1;
    end
    check("abort_no_done", seen, 0);
    step();
    push_a(0, 63);
    start_a = 1; step(); start_a = 0;
    wait_done(64, 1, "restart");
    step();

    // Abort and start together while running
    push_a(0, 5);
    start_a = 1; step(); start_a = 0;
    repeat (5) step();
    abort_a = 1; start_a = 1; step(); abort_a = 0; start_a = 0;
    @(negedge clk);
    check("abort_start_valid", valid_a, 0);
    check("abort_start_done", done_a, 0);
    step(); step();

    // Back-to-back with an ignored mid-sequence start
    push_a(0, 63); push_a(0, 63);
    start_a = 1; step(); start_a = 0;
    repeat (5) step();
    start_a = 1; step(); start_a = 0;
    repeat (57) step();
    start_a = 1; step(); start_a = 0;
    @(negedge clk);
    check("b2b_done", done_a, 1);
    check("b2b_valid", valid_a, 1);
    check("b2b_round", round_a, 0);
    wait_done(63, 1, "b2b");
    step();

    // Asynchronous reset at round 40
    push_a(0, 39);
    start_a = 1; step(); start_a = 0;
    repeat (40) step();
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    step(); step();
    rst_n = 1'b1;
    repeat (5) step();
    @(negedge clk);
    check("post_reset_valid", valid_a, 0);
    check("post_reset_done", done_a, 0);
    check("post_reset_busy", busy_a, 0);
    step();
    push_a(0, 63);
    start_a = 1; step(); start_a = 0;
    wait_done(64, 1, "after_reset");
    repeat (3) step();

    check("q_a_drained", q_a.size(), 0);
    check("q_b_drained", q_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected completion before 200us");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/sha2_k_sequencer.md
# sha2_k_sequencer

Parametrised SHA-2 round-constant sequencer for the AuthenTree hashing datapath. It streams the round constants K[0..N-1] one per cycle into the compression core, replacing per-round combinational lookup with a registered, stallable stream. The stream carries round index and first/last markers. A single parameter selects SHA-256 (64 rounds, 32-bit words) or SHA-512 (80 rounds, 64-bit words), so one block serves both hash variants.

## Interface
- `VARIANT`, default 256: selects the variant. 256 means SHA-256: WORD_W=32, NUM_ROUNDS=64. 512 means SHA-512: WORD_W=64, NUM_ROUNDS=80. Any other value is an elaboration error.
- `WORD_W`, derived localparam, not overridable: 32 or 64.
- `RND_W`, derived localparam: 7 bits, both variants.
- One clock; reset is asynchronous and active-low.
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `start_i`  in  1  request a new 0..N-1 sequence.
- `stall_i`  in  1  consumer not ready; hold current output.
- `abort_i`  in  1  terminate current sequence immediately.
- `k_o`  out  WORD_W  round constant for `round_o`.
- `round_o`  out  RND_W  round index of `k_o`.
- `valid_o`  out  1  `k_o`/`round_o` are meaningful.
- `first_o`  out  1  valid and round_o==0.
- `last_o`  out  1  valid and round_o==NUM_ROUNDS-1.
- `busy_o`  out  1  sequence in progress (equals valid_o).
- `done_o`  out  1  one-cycle pulse after the last round is consumed.

## Operation
- Constants are the FIPS 180-4 values: §4.2.2 for SHA-256, §4.2.3 for SHA-512.
  - Stored as a constant case/ROM indexed by the internal round counter.
  - The output is registered. Indices outside 0..NUM_ROUNDS-1 are unreachable.
- States: IDLE and RUN.
- IDLE:
  - `start_i`=1 (and `abort_i`=0) loads round 0 and enters RUN. Otherwise stay in IDLE.
- RUN, "advance" means `stall_i`=0:
  - Priority 1: `abort_i`=1. Go to IDLE; valid_o drops next cycle; no done_o pulse.
  - Priority 2: `stall_i`=1. All outputs hold. start_i is ignored.
  - Priority 3: advance with round<N-1. round increments and k_o updates to the new round's constant.
  - Priority 4: advance with round==N-1. done_o=1 next cycle.
    - If `start_i`=1 in the same cycle, the next cycle presents round 0 with valid_o=1 (back-to-back, no bubble).
    - Otherwise go to IDLE; valid_o=0 next cycle.
- `start_i` in RUN is ignored except at the last-round advance.
- A consumer takes a word when `valid_o`=1 and `stall_i`=0.
- `stall_i` and `abort_i` in IDLE have no effect.
- In IDLE, `k_o` and `round_o` hold their last values. Consumers qualify them with valid_o.
- `first_o`, `last_o`, `busy_o` are decoded from registered state (glitch-free, no input paths).
- `done_o` is registered.

## Timing
- Reset values: k_o=0, round_o=0, valid_o=0, first_o=0, last_o=0, busy_o=0, done_o=0, state=IDLE.
- Reset is asynchronous assert with synchronous deassert handled upstream.
- Reset asserted mid-sequence clears all of the above within the same cycle. No done_o pulse.
- Start latency: start_i sampled at edge t gives round 0 valid after edge t, i.e. in cycle t+1.
- Throughput: 1 constant per cycle with no stalls.
  - Full sequence occupies N valid cycles: 64 for SHA-256, 80 for SHA-512.
  - done_o is high in cycle t+N+1.
- Stall: every stalled cycle extends the sequence by exactly one cycle. Outputs are bit-stable while stalled.
- Abort at edge t gives valid_o=0 and busy_o=0 in cycle t+1.
- No combinational input-to-output paths.

## Test plan
- Reset with VARIANT=256: all outputs 0. Pulse start_i, no stall. Check:
  - round 0 k_o=32'h428a2f98 with first_o=1.
  - round 10 k_o=32'h243185be.
  - round 63 k_o=32'hc67178f2 with last_o=1.
  - done_o for exactly 1 cycle at t+65; valid_o=0 after.
- VARIANT=512, no stall. Check:
  - round 0 k_o=64'h428a2f98d728ae22.
  - round 79 k_o=64'h6c44198c4a475817 with last_o=1.
  - 80 valid cycles, then done_o.
- VARIANT=256, random stall_i (≈30% duty). Checks:
  - consumed words form exactly rounds 0..63 in order, all constants matching a golden model;
  - outputs unchanged across every stalled cycle;
  - sequence length is 64 plus the number of stall cycles.
- Abort, VARIANT=256:
  - abort_i at round 20 gives valid_o=0 next cycle and no done_o.
  - A later start_i restarts at round 0 with k_o=32'h428a2f98.
  - abort_i and start_i together in RUN: abort wins.
- Back-to-back: start_i held high during the round-63 advance.
  - Next cycle: done_o=1 and valid_o=1 with round_o=0, no bubble.
  - start_i pulses mid-sequence (round 5) are ignored.
- Reset mid-sequence: rst_ni low at round 40 clears all outputs asynchronously. After release the block is in IDLE until start_i.
